// File: rtl/clock_control_root_if.sv
// Status/request bundle between the root clock controller and the clock tree below it.
// The slave side is the controller; the master side aggregates the child requests.
interface clock_control_root_if;
  logic request;
  logic ready;
  logic silent;
  logic starting;
  logic stopping;
  logic clk_en;

  modport master (
    output request,
    input  ready,
    input  silent,
    input  starting,
    input  stopping,
    input  clk_en
  );

  modport slave (
    input  request,
    output ready,
    output silent,
    output starting,
    output stopping,
    output clk_en
  );
endinterface

// File: rtl/clock_control_root.sv
// Root clock controller: answers the aggregated child request with a one-hot status
// set and a clock-gate enable, applying start delay, drain delay and idle hysteresis.
module clock_control_root #(
  parameter int START_CYCLES = 4,
  parameter int STOP_CYCLES  = 4,
  parameter int IDLE_CYCLES  = 8,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_control_root_if.slave  ctl
);

  typedef enum logic [1:0] {
    ST_SILENT   = 2'd0,
    ST_STARTING = 2'd1,
    ST_READY    = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ready_r;
  logic             silent_r;
  logic             starting_r;
  logic             stopping_r;
  logic             clk_en_r;

  // Next-state and shared counter: down-count in STARTING/STOPPING, idle up-count in READY.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_SILENT: begin
        if (ctl.request) begin
          state_nxt_s = ST_STARTING;
          cnt_nxt_s   = START_LOAD;
        end else begin
          state_nxt_s = ST_SILENT;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_STARTING: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_STARTING;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_READY: begin
        // cnt_r holds the low samples seen before this one; this low sample may complete the run
        if (ctl.request) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r >= IDLE_LAST) begin
          state_nxt_s = ST_STOPPING;
          cnt_nxt_s   = STOP_LOAD;
        end else begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_STOPPING: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_SILENT;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_STOPPING;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_SILENT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered one-hot status decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_SILENT;
      cnt_r      <= CNT_ZERO;
      ready_r    <= 1'b0;
      silent_r   <= 1'b1;
      starting_r <= 1'b0;
      stopping_r <= 1'b0;
      clk_en_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ready_r    <= (state_nxt_s == ST_READY);
      silent_r   <= (state_nxt_s == ST_SILENT);
      starting_r <= (state_nxt_s == ST_STARTING);
      stopping_r <= (state_nxt_s == ST_STOPPING);
      clk_en_r   <= (state_nxt_s != ST_SILENT);
    end
  end

  assign ctl.ready    = ready_r;
  assign ctl.silent   = silent_r;
  assign ctl.starting = starting_r;
  assign ctl.stopping = stopping_r;
  assign ctl.clk_en   = clk_en_r;

endmodule

// File: tb/tb_clock_control_root.sv
// Bench for clock_control_root: elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed cycle-by-cycle expectations.
module tb_clock_control_root;
  localparam int START_CYCLES = 4;
  localparam int STOP_CYCLES  = 4;
  localparam int IDLE_CYCLES  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clock_control_root_if bus ();

  clock_control_root #(
    .START_CYCLES(START_CYCLES),
    .STOP_CYCLES (STOP_CYCLES),
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 silent, 1 starting, 2 ready, 3 stopping.
  // elapsed = cycles already spent in the mode (including the one about to start).
  int m_mode    = 0;
  int m_elapsed = 0;
  int m_low_run = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode    <= 0;
      m_elapsed <= 0;
      m_low_run <= 0;
    end else begin
      case (m_mode)
        0: if (bus.request) begin m_mode <= 1; m_elapsed <= 1; end
        1: if (m_elapsed == START_CYCLES) begin m_mode <= 2; m_low_run <= 0; end
           else m_elapsed <= m_elapsed + 1;
        2: if (!bus.request && (m_low_run + 1 == IDLE_CYCLES)) begin
             m_mode <= 3; m_elapsed <= 1;
           end else m_low_run <= bus.request ? 0 : m_low_run + 1;
        3: if (m_elapsed == STOP_CYCLES) m_mode <= 0;
           else m_elapsed <= m_elapsed + 1;
        default: m_mode <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    do_check("model_silent",   {31'd0, bus.silent},   {31'd0, m_mode == 0});
    do_check("model_starting", {31'd0, bus.starting}, {31'd0, m_mode == 1});
    do_check("model_ready",    {31'd0, bus.ready},    {31'd0, m_mode == 2});
    do_check("model_stopping", {31'd0, bus.stopping}, {31'd0, m_mode == 3});
    do_check("model_clk_en",   {31'd0, bus.clk_en},   {31'd0, m_mode != 0});
    do_check("onehot", $countones({bus.ready, bus.silent, bus.starting, bus.stopping}), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected status as {ready, silent, starting, stopping, clk_en}
  task automatic expect_st(input string name, input logic [4:0] exp);
    do_check(name, {27'd0, bus.ready, bus.silent, bus.starting, bus.stopping, bus.clk_en},
             {27'd0, exp});
  endtask

  localparam logic [4:0] E_READY    = 5'b10001;
  localparam logic [4:0] E_SILENT   = 5'b01000;
  localparam logic [4:0] E_STARTING = 5'b00101;
  localparam logic [4:0] E_STOPPING = 5'b00011;

  initial begin
    bus.request = 1'b0;
    tick(3);
    expect_st("reset_state", E_SILENT);
    rst = 1'b0;
    tick(2);
    expect_st("idle_silent", E_SILENT);

    // Wake: request sampled at edge 0 -> starting cycles 1..4, ready at cycle 5
    bus.request = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      expect_st("wake_starting", E_STARTING);
    end
    tick(1);
    expect_st("wake_ready_c5", E_READY);
    tick(2);

    // Hysteresis: 7 lows, 1 high, 8 lows
    bus.request = 1'b0;
    tick(7);
    expect_st("gap7_still_ready", E_READY);
    bus.request = 1'b1;
    tick(1);
    expect_st("after_high_ready", E_READY);
    bus.request = 1'b0;
    tick(7);
    expect_st("low7_ready", E_READY);
    tick(1);
    expect_st("low8_stopping", E_STOPPING);

    // Drain: 4 stopping cycles, then silent
    for (int k = 2; k <= 4; k++) begin
      tick(1);
      expect_st("drain_stopping", E_STOPPING);
    end
    tick(1);
    expect_st("drain_silent", E_SILENT);
    tick(2);

    // Atomic start: drop request on the 2nd starting cycle
    bus.request = 1'b1;
    tick(1);
    expect_st("atomic_c1", E_STARTING);
    tick(1);
    bus.request = 1'b0;
    expect_st("atomic_c2", E_STARTING);
    tick(2);
    expect_st("atomic_c4", E_STARTING);
    for (int k = 5; k <= 12; k++) begin
      tick(1);
      expect_st("atomic_ready", E_READY);
    end
    tick(1);
    expect_st("atomic_stop_c13", E_STOPPING);

    // Atomic stop: raise request during stopping -> one silent cycle, then starting
    bus.request = 1'b1;
    for (int k = 14; k <= 16; k++) begin
      tick(1);
      expect_st("stop_atomic", E_STOPPING);
    end
    tick(1);
    expect_st("one_silent", E_SILENT);
    tick(1);
    expect_st("restart", E_STARTING);
    tick(1);
    expect_st("restart_c2", E_STARTING);

    // Reset mid-STARTING, between clock edges
    #2;
    rst = 1'b1;
    #1;
    expect_st("rst_async", E_SILENT);
    tick(2);
    expect_st("rst_held", E_SILENT);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      expect_st("rst_restart", E_STARTING);
    end
    tick(1);
    expect_st("rst_ready", E_READY);
    tick(3);

    // Reset from READY
    #3;
    rst = 1'b1;
    #1;
    expect_st("rst_ready_async", E_SILENT);
    bus.request = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    expect_st("final_silent", E_SILENT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
